switch_debouncer: RTL
=====================

// Module: switch_debouncer
// PURPOSE
//   Conditions the raw, bouncing 4-bit board switch bank before it reaches the CPU core's
//   `switch` input (read by the LED ON instruction).
//   - Synchronises each bit with two flops.
//   - Accepts a change only after it has been stable for a programmable number of sample ticks.
//   - Outputs a clean level per bit plus one-cycle rise/fall pulses.
// PARAMETERS
//   WIDTH         4     number of switch channels
//   TICK_DIV      1     clk cycles per sample tick (>=1); 1 = sample every cycle
//   STABLE_TICKS  4     consecutive disagreeing ticks needed to accept a change (>=2)
// PORTS
//   clk         input   1      system clock, all state on rising edge
//   n_rst       input   1      asynchronous active-low reset
//   raw_switch  input   WIDTH  asynchronous switch pins
//   switch      output  WIDTH  debounced level; drives cpu.switch
//   rise        output  WIDTH  one-cycle pulse when switch[i] goes 0->1
//   fall        output  WIDTH  one-cycle pulse when switch[i] goes 1->0
// BEHAVIOUR
//   Reset
//   - n_rst low clears everything immediately, regardless of clk:
//     sync flops, prescaler, per-channel state/counters, switch, rise, fall all = 0.
//   Synchroniser
//   - s[i] = raw_switch[i] after 2 flops; no other logic samples raw_switch.
//   Prescaler
//   - pcnt counts 0..TICK_DIV-1, then wraps to 0.
//   - tick = (pcnt == TICK_DIV-1); TICK_DIV=1 gives tick every cycle.
//   - Shared by all channels; free-running from reset release.
//   Per-channel FSM (independent per bit; cnt width $clog2(STABLE_TICKS))
//   - STABLE:
//     - tick && s!=switch -> CHANGING, cnt=1.
//     - Otherwise hold.
//   - CHANGING, on tick:
//     - s==switch -> STABLE, cnt=0. Bounce rejected; no pulse.
//     - Else if cnt==STABLE_TICKS-1 -> switch<=~switch, STABLE, cnt=0, pulse rise or fall.
//     - Else cnt++.
//   - No tick: state and cnt hold.
//   Outputs
//   - switch, rise and fall are all registered.
//   - A rise/fall pulse is high for exactly the first cycle the new level is visible.
//   - rise & fall are never both set on one bit.
//   Latency
//   - With TICK_DIV=1, a clean change on raw_switch is visible on switch
//     STABLE_TICKS+2 cycles later: 2 sync + STABLE_TICKS ticks.
//   - For TICK_DIV>1, add up to TICK_DIV-1 cycles of phase alignment.
//   Boundaries
//   - Glitch shorter than STABLE_TICKS ticks: no output change.
//   - Multiple bits changing in the same cycle: independent; pulses may coincide.
//   - Reset asserted mid-count: count discarded.
//     If raw is high at release, it is debounced afresh and rise fires.
//   - Level held indefinitely: no repeat pulses.
// TESTING (TICK_DIV=1, STABLE_TICKS=4 unless stated)
//   1. Reset, raw=4'b0000 for 10 cycles -> switch=0, rise=fall=0 throughout.
//   2. raw 0->4'b0001 held -> switch=4'b0001 exactly 6 cycles later;
//      rise=4'b0001 for that one cycle only.
//   3. raw[1] pulses high for 3 cycles, then low -> switch[1] stays 0; no rise/fall.
//   4. switch=4'b1111 stable, raw->4'b1010 -> after 6 cycles switch=4'b1010;
//      fall=4'b0101 for one cycle.
//   5. raw=4'b0001 held, n_rst pulsed low at cycle 3 of the count
//      -> switch=0 immediately; switch=4'b0001 6 cycles after release, with rise.
//   6. TICK_DIV=3, raw 0->4'b1000 held -> switch[3] set within 2+4*3+2 cycles;
//      cnt advances only on ticks.

Source files
------------

// File: rtl/switch_debouncer.sv
// rtl/switch_debouncer.sv - two-flop synchroniser, shared sample prescaler and per-channel debounce FSM
// Emits a clean level per switch plus one-cycle rise/fall pulses.
module switch_debouncer #(
    parameter int WIDTH        = 4,
    parameter int TICK_DIV     = 1,
    parameter int STABLE_TICKS = 4
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic [WIDTH-1:0] raw_switch,
    output logic [WIDTH-1:0] switch,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    localparam int CW = $clog2(STABLE_TICKS);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(STABLE_TICKS - 1);
    localparam logic [PW-1:0] PCNT_ONE  = PW'(1);
    localparam logic [PW-1:0] PCNT_LAST = PW'(TICK_DIV - 1);

    typedef enum logic {
        ST_STABLE,
        ST_CHANGING
    } state_t;

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [PW-1:0]    pcnt;
    logic             tick;

    state_t           state_q [WIDTH];
    state_t           state_d [WIDTH];
    logic [CW-1:0]    cnt_q   [WIDTH];
    logic [CW-1:0]    cnt_d   [WIDTH];
    logic [WIDTH-1:0] switch_d;
    logic [WIDTH-1:0] rise_d;
    logic [WIDTH-1:0] fall_d;

    // Only these flops see the asynchronous pins.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw_switch;
            sync2 <= sync1;
        end
    end

    assign tick = (pcnt == PCNT_LAST);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            pcnt <= '0;
        end else if (tick) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + PCNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < WIDTH; i++) begin
                state_q[i] <= ST_STABLE;
                cnt_q[i]   <= '0;
            end
            switch <= '0;
            rise   <= '0;
            fall   <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            switch <= switch_d;
            rise   <= rise_d;
            fall   <= fall_d;
        end
    end

    // cnt counts consecutive ticks on which the synchronised pin disagreed with the output.
    always_comb begin
        switch_d = switch;
        rise_d   = '0;
        fall_d   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                ST_STABLE: begin
                    if (tick && (sync2[i] != switch[i])) begin
                        state_d[i] = ST_CHANGING;
                        cnt_d[i]   = CNT_ONE;
                    end
                end
                ST_CHANGING: begin
                    if (tick) begin
                        if (sync2[i] == switch[i]) begin
                            state_d[i] = ST_STABLE;
                            cnt_d[i]   = '0;
                        end else if (cnt_q[i] == CNT_LAST) begin
                            state_d[i]  = ST_STABLE;
                            cnt_d[i]    = '0;
                            switch_d[i] = sync2[i];
                            rise_d[i]   = sync2[i];
                            fall_d[i]   = ~sync2[i];
                        end else begin
                            cnt_d[i] = cnt_q[i] + CNT_ONE;
                        end
                    end
                end
                default: begin
                    state_d[i] = ST_STABLE;
                    cnt_d[i]   = '0;
                end
            endcase
        end
    end

endmodule
